// File: rtl/ks_i2s_tdm_tx.sv
// I2S / left-justified / TDM master transmitter for the Karplus-Strong output path.
// A frame FIFO feeds a shift register that is serialised on sck_o falling edges.
module ks_i2s_tdm_tx #(
  parameter int AUDIO_DW   = 8,
  parameter int SLOT_DW    = 16,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int SCK_DIV    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          mode,
  input  logic [NUM_CH*AUDIO_DW-1:0]    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underflow,
  input  logic                          underflow_clr,
  output logic                          sck_o,
  output logic                          ws_o,
  output logic                          sd_o
);

  localparam int FW  = NUM_CH * AUDIO_DW;
  localparam int LW  = $clog2(FIFO_DEPTH) + 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int BW  = $clog2(SLOT_DW + 1);
  localparam int SW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DVW = $clog2(SCK_DIV + 1);

  localparam logic [LW-1:0]  DEPTH_L    = LW'(FIFO_DEPTH);
  localparam logic [BW-1:0]  AUD_LIM    = BW'(AUDIO_DW);
  localparam logic [BW-1:0]  SLOT_LAST  = BW'(SLOT_DW - 1);
  localparam logic [SW-1:0]  CH_LAST    = SW'(NUM_CH - 1);
  localparam logic [DVW-1:0] DIV_LAST   = DVW'(SCK_DIV - 1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_nxt;

  logic [FW-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [LW-1:0]  level_q;
  logic [FW-1:0]  frame_sr, sr_nxt;
  logic [DVW-1:0] div_q;
  logic [BW-1:0]  bit_q, bit_nxt;
  logic [SW-1:0]  slot_q, slot_nxt;
  logic           mode_q, mode_nxt, stream_q, stream_nxt, sd_nxt, ws_nxt;
  logic           sck_tick, fall, last_pos, load, stop, pop, push, uflow_set;

  assign in_ready   = (level_q < DEPTH_L);
  assign fifo_level = level_q;
  assign push       = in_valid && in_ready;

  always_comb begin
    sck_tick  = (div_q == DIV_LAST);
    fall      = (state_q == RUN) && sck_tick && sck_o;
    last_pos  = (slot_q == CH_LAST) && (bit_q == SLOT_LAST);
    load      = enable && ((state_q == IDLE) || (fall && last_pos));
    stop      = fall && last_pos && !enable;
    pop       = load && (level_q != '0);
    uflow_set = load && (level_q == '0);

    bit_nxt  = bit_q;
    slot_nxt = slot_q;
    if (load) begin
      bit_nxt  = '0;
      slot_nxt = '0;
    end else if (bit_q == SLOT_LAST) begin
      bit_nxt  = '0;
      slot_nxt = slot_q + SW'(1);
    end else begin
      bit_nxt  = bit_q + BW'(1);
    end

    // Only data bits consume the shift register; slot padding leaves it parked.
    if (load)
      sr_nxt = pop ? mem[rd_ptr] : '0;
    else if (bit_q < AUD_LIM)
      sr_nxt = {frame_sr[FW-2:0], 1'b0};
    else
      sr_nxt = frame_sr;

    stream_nxt = (bit_nxt < AUD_LIM) && sr_nxt[FW-1];
    mode_nxt   = load ? mode : mode_q;
    // I2S emits the previous stream bit; a fresh start from IDLE has none.
    sd_nxt     = mode_nxt ? stream_nxt : ((state_q == RUN) && stream_q);

    if (NUM_CH == 2)
      ws_nxt = (slot_nxt == SW'(1));
    else
      ws_nxt = (slot_nxt == '0) && (bit_nxt == '0);
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (stop)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
    if (load || fall) frame_sr <= sr_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      level_q <= level_q + LW'(1);
      else if (pop && !push) level_q <= level_q - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         underflow <= 1'b0;
    else if (uflow_set) underflow <= 1'b1;
    else if (underflow_clr) underflow <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      sck_o    <= 1'b0;
      ws_o     <= 1'b0;
      sd_o     <= 1'b0;
      bit_q    <= '0;
      slot_q   <= '0;
      mode_q   <= 1'b0;
      stream_q <= 1'b0;
    end else if (stop) begin
      div_q    <= '0;
      sck_o    <= 1'b0;
      ws_o     <= 1'b0;
      sd_o     <= 1'b0;
      stream_q <= 1'b0;
    end else begin
      if ((state_q == RUN) && !sck_tick) div_q <= div_q + DVW'(1);
      else                               div_q <= '0;
      if ((state_q == RUN) && sck_tick)  sck_o <= ~sck_o;
      if (load || fall) begin
        bit_q    <= bit_nxt;
        slot_q   <= slot_nxt;
        mode_q   <= mode_nxt;
        stream_q <= stream_nxt;
        sd_o     <= sd_nxt;
        ws_o     <= ws_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ks_i2s_tdm_tx.sv
// Directed bench for ks_i2s_tdm_tx: stereo LJ/I2S, underflow, back-pressure, TDM and control edges.
module tb_ks_i2s_tdm_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        enable = 0, mode = 0, in_valid = 0, underflow_clr = 0;
  logic [15:0] in_data = '0;
  logic        in_ready, underflow, sck_o, ws_o, sd_o;
  logic [2:0]  fifo_level;

  logic        t_enable = 0, t_mode = 0, t_in_valid = 0, t_underflow_clr = 0;
  logic [31:0] t_in_data = '0;
  logic        t_in_ready, t_underflow, t_sck_o, t_ws_o, t_sd_o;
  logic [2:0]  t_fifo_level;

  ks_i2s_tdm_tx dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .fifo_level(fifo_level), .underflow(underflow), .underflow_clr(underflow_clr),
    .sck_o(sck_o), .ws_o(ws_o), .sd_o(sd_o)
  );

  ks_i2s_tdm_tx #(.AUDIO_DW(8), .SLOT_DW(8), .NUM_CH(4), .FIFO_DEPTH(4), .SCK_DIV(2)) dut_tdm (
    .clk(clk), .rst_n(rst_n), .enable(t_enable), .mode(t_mode),
    .in_data(t_in_data), .in_valid(t_in_valid), .in_ready(t_in_ready),
    .fifo_level(t_fifo_level), .underflow(t_underflow), .underflow_clr(t_underflow_clr),
    .sck_o(t_sck_o), .ws_o(t_ws_o), .sd_o(t_sd_o)
  );

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  q_sd[$], q_ws[$], t_sd[$], t_ws[$];
  time q_t[$];

  always @(posedge sck_o) begin
    q_sd.push_back(sd_o);
    q_ws.push_back(ws_o);
    q_t.push_back($time);
  end

  always @(posedge t_sck_o) begin
    t_sd.push_back(t_sd_o);
    t_ws.push_back(t_ws_o);
  end

  task automatic clear_q();
    q_sd.delete(); q_ws.delete(); q_t.delete();
    t_sd.delete(); t_ws.delete();
  endtask

  task automatic push_frame(input logic [15:0] d);
    @(negedge clk);
    in_data = d; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_bits(input int n, input int budget);
    int c = 0;
    while (q_sd.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if (q_sd.size() < n) begin
      n_bad++;
      $display("FAIL wait_bits: got %0d sck rises, required %0d", q_sd.size(), n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if ({sck_o, ws_o, sd_o, underflow} !== 4'b0) begin n_bad++; $display("FAIL reset_outs: got %b required 0000", {sck_o, ws_o, sd_o, underflow}); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b required 1", in_ready); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL reset_level: got %0d required 0", fifo_level); end
    n_cmp++; if ({t_sck_o, t_ws_o, t_sd_o, t_in_ready} !== 4'b0001) begin n_bad++; $display("FAIL reset_tdm: got %b required 0001", {t_sck_o, t_ws_o, t_sd_o, t_in_ready}); end
    rst_n = 1;
    @(negedge clk);
  endtask

  // One stereo frame {A5,3C}, enable dropped mid-frame so exactly one frame goes out.
  task automatic test_stereo(input logic m, input logic [31:0] exp_sd);
    logic [31:0] exp_ws = 32'h0000FFFF;
    clear_q();
    push_frame(16'hA53C);
    n_cmp++; if (fifo_level !== 3'd1) begin n_bad++; $display("FAIL stereo_level_m%0d: got %0d required 1", m, fifo_level); end
    mode = m; enable = 1;
    repeat (8) @(negedge clk);
    enable = 0;
    wait_bits(32, 400);
    repeat (30) @(negedge clk);
    n_cmp++; if (q_sd.size() !== 32) begin n_bad++; $display("FAIL stereo_count_m%0d: got %0d required 32", m, q_sd.size()); end
    for (int i = 0; i < 32 && i < q_sd.size(); i++) begin
      n_cmp++; if (q_sd[i] !== exp_sd[31-i]) begin n_bad++; $display("FAIL stereo_sd_m%0d bit %0d: got %b required %b", m, i, q_sd[i], exp_sd[31-i]); end
      n_cmp++; if (q_ws[i] !== exp_ws[31-i]) begin n_bad++; $display("FAIL stereo_ws_m%0d bit %0d: got %b required %b", m, i, q_ws[i], exp_ws[31-i]); end
    end
    if (q_t.size() >= 2) begin
      n_cmp++; if (q_t[1] - q_t[0] !== 40) begin n_bad++; $display("FAIL sck_period: got %0t required 40", q_t[1] - q_t[0]); end
    end
    n_cmp++; if ({sck_o, ws_o, sd_o} !== 3'b000) begin n_bad++; $display("FAIL stop_outs_m%0d: got %b required 000", m, {sck_o, ws_o, sd_o}); end
    n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL stereo_uflow_m%0d: got %b required 0", m, underflow); end
  endtask

  task automatic test_underflow();
    logic [63:0] exp_sd = {32'hA5003C00, 32'h0};
    clear_q();
    push_frame(16'hA53C);
    mode = 1; enable = 1;
    repeat (60) @(negedge clk);
    n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL uflow_early: got %b required 0", underflow); end
    repeat (110) @(negedge clk);
    enable = 0;
    n_cmp++; if (underflow !== 1'b1) begin n_bad++; $display("FAIL uflow_set: got %b required 1", underflow); end
    wait_bits(64, 600);
    repeat (30) @(negedge clk);
    n_cmp++; if (q_sd.size() !== 64) begin n_bad++; $display("FAIL uflow_count: got %0d required 64", q_sd.size()); end
    for (int i = 0; i < 64 && i < q_sd.size(); i++) begin
      n_cmp++; if (q_sd[i] !== exp_sd[63-i]) begin n_bad++; $display("FAIL uflow_sd bit %0d: got %b required %b", i, q_sd[i], exp_sd[63-i]); end
    end
    underflow_clr = 1;
    @(negedge clk);
    underflow_clr = 0;
    n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL uflow_clr: got %b required 0", underflow); end
    // Entry with an empty FIFO sets the flag on the same edge as the clear.
    enable = 1; underflow_clr = 1;
    @(negedge clk);
    underflow_clr = 0;
    n_cmp++; if (underflow !== 1'b1) begin n_bad++; $display("FAIL uflow_set_wins: got %b required 1", underflow); end
    repeat (6) @(negedge clk);
    enable = 0;
    repeat (150) @(negedge clk);
    n_cmp++; if ({sck_o, ws_o, sd_o} !== 3'b000) begin n_bad++; $display("FAIL uflow_idle: got %b required 000", {sck_o, ws_o, sd_o}); end
    underflow_clr = 1;
    @(negedge clk);
    underflow_clr = 0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] tbl [6] = '{16'h1081, 16'h2192, 16'h32A3, 16'h43B4, 16'hFFFF, 16'hFFFF};
    logic [7:0]  b;
    logic [7:0]  e;
    clear_q();
    mode = 1;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      in_data = tbl[k]; in_valid = 1;
      @(negedge clk);
    end
    in_valid = 0;
    n_cmp++; if (fifo_level !== 3'd4) begin n_bad++; $display("FAIL bp_level_full: got %0d required 4", fifo_level); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready: got %b required 0", in_ready); end
    enable = 1;
    @(negedge clk);
    n_cmp++; if (fifo_level !== 3'd3) begin n_bad++; $display("FAIL drain_entry: got %0d required 3", fifo_level); end
    repeat (127) @(negedge clk);
    n_cmp++; if (fifo_level !== 3'd3) begin n_bad++; $display("FAIL drain_before: got %0d required 3", fifo_level); end
    @(negedge clk);
    n_cmp++; if (fifo_level !== 3'd2) begin n_bad++; $display("FAIL drain_1: got %0d required 2", fifo_level); end
    repeat (128) @(negedge clk);
    n_cmp++; if (fifo_level !== 3'd1) begin n_bad++; $display("FAIL drain_2: got %0d required 1", fifo_level); end
    repeat (140) @(negedge clk);
    n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL drain_3: got %0d required 0", fifo_level); end
    enable = 0;
    wait_bits(128, 400);
    repeat (30) @(negedge clk);
    n_cmp++; if (q_sd.size() !== 128) begin n_bad++; $display("FAIL bp_count: got %0d required 128", q_sd.size()); end
    for (int f = 0; f < 4; f++) begin
      for (int c = 0; c < 2; c++) begin
        b = '0;
        for (int i = 0; i < 8; i++)
          if (f*32 + c*16 + i < q_sd.size()) b[7-i] = q_sd[f*32 + c*16 + i];
        e = (c == 0) ? tbl[f][15:8] : tbl[f][7:0];
        n_cmp++; if (b !== e) begin n_bad++; $display("FAIL bp_byte f%0d c%0d: got %h required %h", f, c, b, e); end
      end
    end
    n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL bp_uflow: got %b required 0", underflow); end
  endtask

  task automatic test_tdm();
    logic [31:0] exp_sd = 32'h11223344;
    logic [31:0] exp_ws = 32'h80000000;
    int c = 0;
    int highs = 0;
    clear_q();
    @(negedge clk);
    t_in_data = 32'h11223344; t_in_valid = 1;
    @(negedge clk);
    t_in_valid = 0; t_mode = 1; t_enable = 1;
    repeat (8) @(negedge clk);
    t_enable = 0;
    while (t_sd.size() < 32 && c < 400) begin
      @(negedge clk);
      c++;
    end
    repeat (30) @(negedge clk);
    n_cmp++; if (t_sd.size() !== 32) begin n_bad++; $display("FAIL tdm_count: got %0d required 32", t_sd.size()); end
    for (int i = 0; i < 32 && i < t_sd.size(); i++) begin
      n_cmp++; if (t_sd[i] !== exp_sd[31-i]) begin n_bad++; $display("FAIL tdm_sd bit %0d: got %b required %b", i, t_sd[i], exp_sd[31-i]); end
      n_cmp++; if (t_ws[i] !== exp_ws[31-i]) begin n_bad++; $display("FAIL tdm_ws bit %0d: got %b required %b", i, t_ws[i], exp_ws[31-i]); end
      if (t_ws[i]) highs++;
    end
    n_cmp++; if (highs !== 1) begin n_bad++; $display("FAIL tdm_ws_highs: got %0d required 1", highs); end
    n_cmp++; if ({t_sck_o, t_ws_o, t_sd_o} !== 3'b000) begin n_bad++; $display("FAIL tdm_stop: got %b required 000", {t_sck_o, t_ws_o, t_sd_o}); end
  endtask

  task automatic test_reset_mid();
    int c = 0;
    push_frame(16'h5A5A);
    push_frame(16'h1234);
    mode = 1; enable = 1;
    @(negedge clk);
    while (sck_o !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    n_cmp++; if (sck_o !== 1'b1) begin n_bad++; $display("FAIL mid_running: sck got %b required 1", sck_o); end
    n_cmp++; if (fifo_level !== 3'd1) begin n_bad++; $display("FAIL mid_level: got %0d required 1", fifo_level); end
    #2 rst_n = 0;
    #1;
    n_cmp++; if ({sck_o, ws_o, sd_o, underflow} !== 4'b0) begin n_bad++; $display("FAIL mid_rst_outs: got %b required 0000", {sck_o, ws_o, sd_o, underflow}); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL mid_rst_level: got %0d required 0", fifo_level); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_ready: got %b required 1", in_ready); end
    enable = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (10) @(negedge clk);
    n_cmp++; if (sck_o !== 1'b0) begin n_bad++; $display("FAIL post_rst_idle: sck got %b required 0", sck_o); end
  endtask

  initial begin
    test_reset();
    test_stereo(1'b1, 32'hA5003C00);
    test_stereo(1'b0, 32'h52801E00);
    test_underflow();
    test_back_to_back();
    test_tdm();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
